// File: rtl/keypad_event_scanner_if.sv
// Key event stream between the keypad scanner and its consumer.
// Head-of-queue key code with a valid/ready handshake.
interface keypad_event_scanner_if #(
    parameter int KW = 4
);
    logic          ev_valid;
    logic [KW-1:0] ev_code;
    logic          ev_ready;

    modport master (
        output ev_valid,
        output ev_code,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        output ev_ready
    );
endinterface

// File: rtl/keypad_event_scanner.sv
// Matrix keypad front end: row scan, whole-frame debounce,
// new-press detection and a show-ahead key event queue.
module keypad_event_scanner #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 50000,
    parameter  int DEB_FRAMES = 4,
    parameter  int FIFO_DEPTH = 8,
    parameter  int CNT_W      = 8,
    localparam int N          = ROWS * COLS,
    localparam int KW         = $clog2(N),
    localparam int FW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic [COLS-1:0]       col,
    output logic [ROWS-1:0]       row,
    output logic [N-1:0]          key_state,
    output logic                  multi,
    keypad_event_scanner_if.master ev,
    output logic [FW-1:0]         fifo_count,
    output logic                  overflow,
    input  logic                  clr_ovf,
    output logic [CNT_W-1:0]      press_cnt
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(ROWS);
    localparam int SW = $clog2(DEB_FRAMES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DW-1:0]  div_q;
    logic [IW-1:0]  idx_q;
    logic [N-1:0]   raw_q;
    logic [N-1:0]   prev_q;
    logic [SW-1:0]  stab_q;
    logic [N-1:0]   pending_q;
    logic [FW-1:0]  count_q;
    logic [PW-1:0]  wr_q;
    logic [PW-1:0]  rd_q;
    logic [KW-1:0]  mem [FIFO_DEPTH];

    logic           settle;
    logic           frame_done;
    logic [KW-1:0]  sh;
    logic [N-1:0]   slot_mask;
    logic [N-1:0]   slot_bits;
    logic [N-1:0]   frame;
    logic           same;
    logic [SW-1:0]  stab_nxt;
    logic           accept;
    logic [N-1:0]   new_press;
    logic           has_ev;
    logic [KW-1:0]  lsb_idx;
    logic [N-1:0]   clr_mask;
    logic           pop;
    logic           push;
    logic           drop;

    assign settle     = div_q == DW'(SCAN_DIV - 1);
    assign frame_done = settle && (idx_q == IW'(ROWS - 1));
    assign row        = ~(ROWS'(1) << idx_q);

    // The current row's column sense patched into the last captured frame.
    assign sh        = KW'(idx_q) * KW'(COLS);
    assign slot_mask = N'({COLS{1'b1}}) << sh;
    assign slot_bits = N'(~col) << sh;
    assign frame     = (raw_q & ~slot_mask) | slot_bits;

    // Stable count after this frame: restart on change, saturate when steady.
    always_comb begin
        stab_nxt = SW'(1);
        if (same) begin
            stab_nxt = (stab_q == SW'(DEB_FRAMES)) ? stab_q
                                                   : stab_q + SW'(1);
        end
    end

    assign same      = frame == prev_q;
    assign accept    = frame_done && same &&
                       (stab_nxt == SW'(DEB_FRAMES)) &&
                       (frame != key_state);
    assign new_press = accept ? (frame & ~key_state) : '0;

    // Lowest pending key index; it is the next one to be queued.
    always_comb begin
        lsb_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) lsb_idx = KW'(i);
        end
    end

    assign has_ev   = |pending_q;
    assign clr_mask = N'(has_ev) << lsb_idx;
    assign pop      = (count_q != '0) && ev.ev_ready;
    assign push     = has_ev && ((count_q != FW'(FIFO_DEPTH)) || pop);
    assign drop     = has_ev && !push;

    assign ev.ev_valid = count_q != '0;
    assign ev.ev_code  = ev.ev_valid ? mem[rd_q] : '0;
    assign fifo_count  = count_q;

    // Row slot divider and row index.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (settle) begin
            div_q <= '0;
            idx_q <= (idx_q == IW'(ROWS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Raw capture, frame-level debounce and key state update.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            raw_q     <= '0;
            prev_q    <= '0;
            stab_q    <= '0;
            key_state <= '0;
        end else begin
            if (settle) raw_q <= frame;
            if (frame_done) begin
                prev_q <= frame;
                stab_q <= stab_nxt;
            end
            if (accept) key_state <= frame;
        end
    end

    // Multi-key flag, one clock behind key_state.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) multi <= 1'b0;
        else       multi <= |(key_state & (key_state - N'(1)));
    end

    // Pending press drain, press counter and sticky overflow.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            pending_q <= '0;
            press_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | new_press;
            if (has_ev)       press_cnt <= press_cnt + CNT_W'(1);
            if (drop)         overflow  <= 1'b1;
            else if (clr_ovf) overflow  <= 1'b0;
        end
    end

    // Event queue storage and pointers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_q] <= lsb_idx;
                wr_q      <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            count_q <= count_q + FW'(push) - FW'(pop);
        end
    end
endmodule

// File: tb/tb_keypad_event_scanner.sv
// Bench for keypad_event_scanner: directed keypad scenarios plus
// random key/consumer activity against a queue-based reference.
module tb_keypad_event_scanner;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SDIV  = 4;
    localparam int DEB   = 2;
    localparam int DEPTH = 4;
    localparam int NK    = ROWS * COLS;

    logic             clk = 1'b0;
    logic             RSTn = 1'b0;
    logic [COLS-1:0]  col;
    logic [ROWS-1:0]  row;
    logic [NK-1:0]    key_state;
    logic             multi;
    logic [2:0]       fifo_count;
    logic             overflow;
    logic             clr_ovf = 1'b0;
    logic [7:0]       press_cnt;
    logic [NK-1:0]    keys = '0;
    bit               chk_on = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    keypad_event_scanner_if #(.KW(4)) ev_if ();

    keypad_event_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV),
        .DEB_FRAMES(DEB), .FIFO_DEPTH(DEPTH), .CNT_W(8)
    ) dut (
        .clk(clk), .RSTn(RSTn), .col(col), .row(row),
        .key_state(key_state), .multi(multi), .ev(ev_if),
        .fifo_count(fifo_count), .overflow(overflow),
        .clr_ovf(clr_ovf), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its column low while its row is driven.
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row[r] && keys[r*COLS+c]) col[c] = 1'b0;
    end

    // Reference model state.
    int            mt;
    logic [NK-1:0] mraw, mprev, mks;
    int            mstab;
    int            pend[$];
    int            fq[$];
    bit            movf, mm;
    int            mpc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mt = 0; mraw = '0; mprev = '0; mks = '0; mstab = 0;
        pend.delete(); fq.delete();
        movf = 0; mm = 0; mpc = 0;
    endtask

    task automatic model_step();
        int  code, r;
        bit  pop, push, drop, dup;
        code = 0; push = 0; drop = 0;
        pop = (fq.size() != 0) && ev_if.ev_ready;
        if (pend.size() != 0) begin
            code = pend.pop_front();
            mpc = (mpc + 1) % 256;
            if (fq.size() - int'(pop) < DEPTH) push = 1;
            else drop = 1;
        end
        if (pop) void'(fq.pop_front());
        if (push) fq.push_back(code);
        if (drop) movf = 1;
        else if (clr_ovf) movf = 0;
        mm = $countones(mks) > 1;
        if (mt % SDIV == SDIV - 1) begin
            r = (mt / SDIV) % ROWS;
            for (int c = 0; c < COLS; c++) mraw[r*COLS+c] = keys[r*COLS+c];
            if (r == ROWS - 1) begin
                if (mraw == mprev) begin
                    mstab = (mstab + 1 > DEB) ? DEB : mstab + 1;
                    if (mstab == DEB && mraw != mks) begin
                        for (int i = 0; i < NK; i++) begin
                            if (mraw[i] && !mks[i]) begin
                                dup = 0;
                                foreach (pend[j]) if (pend[j] == i) dup = 1;
                                if (!dup) pend.push_back(i);
                            end
                        end
                        pend.sort();
                        mks = mraw;
                    end
                end else begin
                    mstab = 1;
                end
                mprev = mraw;
            end
        end
        mt++;
    endtask

    task automatic check_all();
        logic [3:0] erow;
        erow = ~(4'b0001 << ((mt / SDIV) % ROWS));
        chk("row", row, erow);
        chk("key_state", key_state, mks);
        chk("multi", multi, mm);
        chk("ev_valid", ev_if.ev_valid, fq.size() != 0);
        chk("ev_code", ev_if.ev_code, (fq.size() != 0) ? fq[0] : 0);
        chk("fifo_count", fifo_count, fq.size());
        chk("overflow", overflow, movf);
        chk("press_cnt", press_cnt, mpc);
    endtask

    initial forever begin
        @(posedge clk);
        if (RSTn) model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) check_all();
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_row"}, row, 4'b1110);
        chk({tag, "_ks"}, key_state, 16'h0000);
        chk({tag, "_valid"}, ev_if.ev_valid, 1'b0);
        chk({tag, "_cnt"}, fifo_count, 3'd0);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_press"}, press_cnt, 8'd0);
    endtask

    initial begin
        bit hit;
        ev_if.ev_ready = 1'b0;
        model_reset();
        step(3);
        chk_on = 1'b1;
        zero_check("rst");
        RSTn = 1'b1;
        step(40);

        // Single press r2c1, consumer stalled.
        keys[9] = 1'b1;
        step(60);
        chk("ks_single", key_state, 16'h0200);
        chk("code_single", ev_if.ev_code, 4'd9);
        chk("press_single", press_cnt, 8'd1);
        ev_if.ev_ready = 1'b1;
        step(2);
        chk("valid_drained", ev_if.ev_valid, 1'b0);
        keys = '0;
        step(60);

        // Bouncing r0c0, one toggle per frame, then held.
        for (int k = 0; k < 5; k++) begin
            keys[0] = ~keys[0];
            step(SDIV * ROWS);
        end
        keys[0] = 1'b1;
        step(60);
        keys = '0;
        step(60);

        // Two keys closed together.
        keys = 16'h1080;
        step(60);
        chk("ks_dual", key_state, 16'h1080);
        chk("multi_dual", multi, 1'b1);
        keys = '0;
        step(60);

        // Five presses into a four-entry queue.
        ev_if.ev_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            keys[k] = 1'b1;
            step(50);
        end
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_clear", overflow, 1'b0);
        ev_if.ev_ready = 1'b1;
        step(10);
        keys = '0;
        step(60);

        // Random keypad and consumer activity.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(29) == 0) keys[$urandom_range(NK-1)] ^= 1'b1;
            ev_if.ev_ready = ($urandom_range(2) != 0);
            clr_ovf = ($urandom_range(19) == 0);
            step(1);
        end

        // Reset while presses are still draining.
        keys = '0;
        clr_ovf = 1'b0;
        ev_if.ev_ready = 1'b1;
        step(80);
        ev_if.ev_ready = 1'b0;
        keys = 16'h8421;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            step(1);
            if (fq.size() == 2 && pend.size() != 0) hit = 1;
        end
        chk("drain_reached", hit, 1'b1);
        RSTn = 1'b0;
        model_reset();
        #1;
        zero_check("mid");
        keys = '0;
        step(2);
        RSTn = 1'b1;
        step(60);
        chk("no_event_after_rst", press_cnt, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
